// File: rtl/stream_simd_packer_if.sv
// rtl/stream_simd_packer_if.sv - command, narrow input stream and FIFO read bundle of the SIMD packer
interface stream_simd_packer_if #(
  parameter int SIMD_WIDTH = 4,
  parameter int W_D        = 32,
  parameter int W_LEN      = 32
);
  logic [W_LEN-1:0]          CMD_LEN;
  logic                      CMD_VALID;
  logic                      CMD_READY;
  logic [W_D-1:0]            IN_D;
  logic                      IN_VALID;
  logic                      IN_READY;
  logic [W_D*SIMD_WIDTH-1:0] Q;
  logic                      DEQ;
  logic                      EMPTY;
  logic                      ALM_EMPTY;
  logic                      DONE;
  logic                      BUSY;

  modport master (
    output CMD_LEN, CMD_VALID, IN_D, IN_VALID, DEQ,
    input  CMD_READY, IN_READY, Q, EMPTY, ALM_EMPTY, DONE, BUSY
  );

  modport slave (
    input  CMD_LEN, CMD_VALID, IN_D, IN_VALID, DEQ,
    output CMD_READY, IN_READY, Q, EMPTY, ALM_EMPTY, DONE, BUSY
  );
endinterface

// File: rtl/stream_simd_packer.sv
// rtl/stream_simd_packer.sv - packs SIMD_WIDTH narrow words per entry into a FIFO with registered read
module stream_simd_packer #(
  parameter int SIMD_WIDTH     = 4,
  parameter int LOG_SIMD_WIDTH = 2,
  parameter int W_D            = 32,
  parameter int W_A            = 10,
  parameter int W_LEN          = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  stream_simd_packer_if.slave  bus
);
  localparam int LW    = (LOG_SIMD_WIDTH > 0) ? LOG_SIMD_WIDTH : 1;
  localparam int W_Q   = W_D * SIMD_WIDTH;
  localparam int DEPTH = 1 << W_A;
  localparam logic [W_A:0] FULL_CNT = {1'b1, {W_A{1'b0}}};

  typedef enum logic [1:0] {IDLE, PACK, FIN} state_e;

  state_e           state_q, state_d;
  logic [W_LEN-1:0] remaining_q, remaining_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [W_Q-1:0]   staging_q, staging_d;
  logic [W_A-1:0]   wr_ptr_q, wr_ptr_d;
  logic [W_A-1:0]   rd_ptr_q, rd_ptr_d;
  logic [W_A:0]     count_q, count_d;
  logic [W_Q-1:0]   q_q, q_d;
  logic [W_Q-1:0]   mem_q [DEPTH];

  logic           cmd_ready, in_ready, done, busy;
  logic           full, cmd_fire, in_fire, deq_fire, push, last_word, group_end;
  logic [W_Q-1:0] wr_word;

  assign full      = (count_q == FULL_CNT);
  assign cmd_fire  = bus.CMD_VALID && cmd_ready;
  assign in_fire   = bus.IN_VALID && in_ready;
  assign deq_fire  = bus.DEQ && (count_q != '0);
  assign last_word = (remaining_q == W_LEN'(1));
  assign group_end = (lane_q == LW'(SIMD_WIDTH - 1)) || last_word;
  assign push      = in_fire && group_end;

  // Upper lanes of staging are always zero, so a short final group is padded for free.
  always_comb begin
    wr_word = staging_q;
    for (int i = 0; i < SIMD_WIDTH; i++) begin
      if (lane_q == LW'(i)) wr_word[i*W_D +: W_D] = bus.IN_D;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_fire) state_d = (bus.CMD_LEN == '0) ? FIN : PACK;
      PACK:    if (in_fire && last_word) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    done      = (state_q == FIN);
    in_ready  = (state_q == PACK) && !full;
  end

  always_comb begin
    remaining_d = remaining_q;
    lane_d      = lane_q;
    staging_d   = staging_q;
    if (cmd_fire) begin
      remaining_d = bus.CMD_LEN;
      lane_d      = '0;
      staging_d   = '0;
    end else if (in_fire) begin
      remaining_d = remaining_q - W_LEN'(1);
      if (group_end) begin
        lane_d    = '0;
        staging_d = '0;
      end else begin
        lane_d    = lane_q + LW'(1);
        staging_d = wr_word;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + W_A'(push);
    rd_ptr_d = rd_ptr_q + W_A'(deq_fire);
    count_d  = count_q;
    if (push && !deq_fire)      count_d = count_q + (W_A+1)'(1);
    else if (!push && deq_fire) count_d = count_q - (W_A+1)'(1);
    q_d = deq_fire ? mem_q[rd_ptr_q] : q_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      remaining_q <= '0;
      lane_q      <= '0;
      staging_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      q_q         <= '0;
    end else begin
      remaining_q <= remaining_d;
      lane_q      <= lane_d;
      staging_q   <= staging_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      q_q         <= q_d;
    end
  end

  // Storage array carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= wr_word;
  end

  assign bus.CMD_READY = cmd_ready;
  assign bus.IN_READY  = in_ready;
  assign bus.DONE      = done;
  assign bus.BUSY      = busy;
  assign bus.Q         = q_q;
  assign bus.EMPTY     = (count_q == '0);
  assign bus.ALM_EMPTY = (count_q <= (W_A+1)'(1));
endmodule

// File: tb/tb_stream_simd_packer.sv
// tb/tb_stream_simd_packer.sv - directed self-checking bench for stream_simd_packer
module tb_stream_simd_packer;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_simd_packer_if #(.SIMD_WIDTH(4), .W_D(32), .W_LEN(32)) bus ();

  stream_simd_packer #(
    .SIMD_WIDTH(4), .LOG_SIMD_WIDTH(2), .W_D(32), .W_A(2), .W_LEN(32)
  ) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  function automatic logic [127:0] pk(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_cmd(input int len);
    bus.CMD_LEN   = 32'(len);
    bus.CMD_VALID = 1'b1;
    tick();
    bus.CMD_VALID = 1'b0;
  endtask

  task automatic feed(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      bus.IN_D     = 32'(first + i);
      bus.IN_VALID = 1'b1;
      tick();
    end
    bus.IN_VALID = 1'b0;
  endtask

  task automatic deq_one();
    bus.DEQ = 1'b1;
    tick();
    bus.DEQ = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tick();
    n_checks++; if (bus.CMD_READY !== 1'b1) begin n_fail++; $display("FAIL por_cmd_ready: got %b want 1", bus.CMD_READY); end
    n_checks++; if (bus.IN_READY !== 1'b0) begin n_fail++; $display("FAIL por_in_ready: got %b want 0", bus.IN_READY); end
    n_checks++; if (bus.EMPTY !== 1'b1 || bus.ALM_EMPTY !== 1'b1) begin n_fail++; $display("FAIL por_empty: got %b/%b want 1/1", bus.EMPTY, bus.ALM_EMPTY); end
    n_checks++; if (bus.Q !== 128'h0 || bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL por_q_done_busy: got %h/%b/%b want 0/0/0", bus.Q, bus.DONE, bus.BUSY); end
    rst_n = 1'b1;
    tick();
    start_cmd(4);
    feed(1, 4);
    tick();
    deq_one();
    n_checks++; if (bus.Q !== pk(1, 2, 3, 4)) begin n_fail++; $display("FAIL pre_reset_q: got %h want %h", bus.Q, pk(1, 2, 3, 4)); end
    start_cmd(6);
    feed(5, 5);
    n_checks++; if (bus.EMPTY !== 1'b0 || bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL pre_reset_traffic: got empty %b busy %b want 0/1", bus.EMPTY, bus.BUSY); end
    rst_n = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (bus.EMPTY !== 1'b1 || bus.ALM_EMPTY !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b/%b want 1/1", bus.EMPTY, bus.ALM_EMPTY); end
    n_checks++; if (bus.IN_READY !== 1'b0 || bus.CMD_READY !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got in %b cmd %b want 0/1", bus.IN_READY, bus.CMD_READY); end
    n_checks++; if (bus.Q !== 128'h0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin n_fail++; $display("FAIL rst_q_busy: got %h/%b/%b want 0/0/0", bus.Q, bus.BUSY, bus.DONE); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [127:0] q0;
    int sum;
    bus.CMD_LEN   = 32'd8;
    bus.CMD_VALID = 1'b1;
    n_checks++; if (bus.CMD_READY !== 1'b1) begin n_fail++; $display("FAIL basic_cmd_ready: got %b want 1", bus.CMD_READY); end
    tick();
    bus.CMD_VALID = 1'b0;
    n_checks++; if (bus.IN_READY !== 1'b1 || bus.BUSY !== 1'b1 || bus.CMD_READY !== 1'b0) begin n_fail++; $display("FAIL basic_pack_entry: got in %b busy %b cmd %b want 1/1/0", bus.IN_READY, bus.BUSY, bus.CMD_READY); end
    for (int i = 1; i <= 8; i++) begin
      bus.IN_D     = 32'(i);
      bus.IN_VALID = 1'b1;
      n_checks++; if (bus.IN_READY !== 1'b1 || bus.DONE !== 1'b0) begin n_fail++; $display("FAIL basic_word%0d: got ready %b done %b want 1/0", i, bus.IN_READY, bus.DONE); end
      tick();
    end
    bus.IN_VALID = 1'b0;
    n_checks++; if (bus.DONE !== 1'b1 || bus.CMD_READY !== 1'b0) begin n_fail++; $display("FAIL basic_done: got done %b cmd %b want 1/0", bus.DONE, bus.CMD_READY); end
    n_checks++; if (bus.EMPTY !== 1'b0 || bus.ALM_EMPTY !== 1'b0) begin n_fail++; $display("FAIL basic_count2: got %b/%b want 0/0", bus.EMPTY, bus.ALM_EMPTY); end
    tick();
    n_checks++; if (bus.DONE !== 1'b0 || bus.CMD_READY !== 1'b1 || bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL basic_after_done: got done %b cmd %b busy %b want 0/1/0", bus.DONE, bus.CMD_READY, bus.BUSY); end
    deq_one();
    q0 = bus.Q;
    n_checks++; if (q0 !== pk(1, 2, 3, 4)) begin n_fail++; $display("FAIL basic_q0: got %h want %h", q0, pk(1, 2, 3, 4)); end
    n_checks++; if (bus.EMPTY !== 1'b0 || bus.ALM_EMPTY !== 1'b1) begin n_fail++; $display("FAIL basic_count1: got %b/%b want 0/1", bus.EMPTY, bus.ALM_EMPTY); end
    deq_one();
    n_checks++; if (bus.Q !== pk(5, 6, 7, 8)) begin n_fail++; $display("FAIL basic_q1: got %h want %h", bus.Q, pk(5, 6, 7, 8)); end
    n_checks++; if (bus.EMPTY !== 1'b1) begin n_fail++; $display("FAIL basic_drained: got %b want 1", bus.EMPTY); end
    sum = 0;
    for (int l = 0; l < 4; l++) sum += int'(q0[l*32 +: 32]) + int'(bus.Q[l*32 +: 32]);
    n_checks++; if (sum !== 36) begin n_fail++; $display("FAIL basic_lane_sum: got %0d want 36", sum); end
  endtask

  task automatic test_partial();
    start_cmd(5);
    feed(1, 5);
    n_checks++; if (bus.DONE !== 1'b1) begin n_fail++; $display("FAIL partial_done: got %b want 1", bus.DONE); end
    tick();
    deq_one();
    n_checks++; if (bus.Q !== pk(1, 2, 3, 4)) begin n_fail++; $display("FAIL partial_q0: got %h want %h", bus.Q, pk(1, 2, 3, 4)); end
    deq_one();
    n_checks++; if (bus.Q !== pk(5, 0, 0, 0)) begin n_fail++; $display("FAIL partial_q1: got %h want %h", bus.Q, pk(5, 0, 0, 0)); end
    n_checks++; if (bus.EMPTY !== 1'b1) begin n_fail++; $display("FAIL partial_empty: got %b want 1", bus.EMPTY); end
    deq_one();
    n_checks++; if (bus.Q !== pk(5, 0, 0, 0) || bus.EMPTY !== 1'b1) begin n_fail++; $display("FAIL partial_deq_empty: got %h/%b want %h/1", bus.Q, bus.EMPTY, pk(5, 0, 0, 0)); end
  endtask

  task automatic test_zero_len();
    start_cmd(0);
    n_checks++; if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b1 || bus.IN_READY !== 1'b0) begin n_fail++; $display("FAIL zero_fin: got done %b busy %b in %b want 1/1/0", bus.DONE, bus.BUSY, bus.IN_READY); end
    tick();
    n_checks++; if (bus.DONE !== 1'b0 || bus.CMD_READY !== 1'b1) begin n_fail++; $display("FAIL zero_idle: got done %b cmd %b want 0/1", bus.DONE, bus.CMD_READY); end
    n_checks++; if (bus.EMPTY !== 1'b1) begin n_fail++; $display("FAIL zero_no_push: got %b want 1", bus.EMPTY); end
  endtask

  task automatic test_full();
    start_cmd(20);
    feed(1, 16);
    n_checks++; if (bus.IN_READY !== 1'b0 || bus.ALM_EMPTY !== 1'b0) begin n_fail++; $display("FAIL full_stall: got in %b alm %b want 0/0", bus.IN_READY, bus.ALM_EMPTY); end
    bus.IN_D     = 32'd17;
    bus.IN_VALID = 1'b1;
    tick();
    n_checks++; if (bus.IN_READY !== 1'b0 || bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL full_hold: got in %b busy %b want 0/1", bus.IN_READY, bus.BUSY); end
    deq_one();
    n_checks++; if (bus.IN_READY !== 1'b1) begin n_fail++; $display("FAIL full_reopen: got %b want 1", bus.IN_READY); end
    n_checks++; if (bus.Q !== pk(1, 2, 3, 4)) begin n_fail++; $display("FAIL full_q0: got %h want %h", bus.Q, pk(1, 2, 3, 4)); end
    feed(17, 4);
    n_checks++; if (bus.DONE !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b want 1", bus.DONE); end
    tick();
    for (int e = 1; e < 5; e++) begin
      deq_one();
      n_checks++; if (bus.Q !== pk(4*e+1, 4*e+2, 4*e+3, 4*e+4)) begin n_fail++; $display("FAIL full_q%0d: got %h want %h", e, bus.Q, pk(4*e+1, 4*e+2, 4*e+3, 4*e+4)); end
    end
    n_checks++; if (bus.EMPTY !== 1'b1) begin n_fail++; $display("FAIL full_drained: got %b want 1", bus.EMPTY); end
  endtask

  task automatic test_abort();
    start_cmd(8);
    feed(1, 3);
    rst_n = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();
    start_cmd(4);
    feed(9, 4);
    n_checks++; if (bus.EMPTY !== 1'b0 || bus.ALM_EMPTY !== 1'b1) begin n_fail++; $display("FAIL abort_one_entry: got %b/%b want 0/1", bus.EMPTY, bus.ALM_EMPTY); end
    tick();
    deq_one();
    n_checks++; if (bus.Q !== pk(9, 10, 11, 12)) begin n_fail++; $display("FAIL abort_q: got %h want %h", bus.Q, pk(9, 10, 11, 12)); end
    n_checks++; if (bus.EMPTY !== 1'b1) begin n_fail++; $display("FAIL abort_drained: got %b want 1", bus.EMPTY); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.CMD_LEN   = '0;
    bus.CMD_VALID = 1'b0;
    bus.IN_D      = '0;
    bus.IN_VALID  = 1'b0;
    bus.DEQ       = 1'b0;
    test_reset();
    test_basic();
    test_partial();
    test_zero_len();
    test_full();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
